// File: rtl/bank_pkg.sv
// Shared constants and types for the bank return path.
package bank_pkg;

  localparam int CH_NUM_DEF = 3;
  localparam int ROB_W_DEF  = 3;
  localparam int DATA_W_DEF = 128;
  localparam int DEPTH_DEF  = 4;

  typedef struct packed {
    logic [ROB_W_DEF-1:0]  rob_num;
    logic [DATA_W_DEF-1:0] data;
  } rtn_beat_t;

  // Channel-id width; a single channel still needs one id bit.
  function automatic int ch_w_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bank_xbar_rtn_buf_if.sv
// Return-path bundle: sc_xbar input handshake plus per-channel crossbar outputs.
// Signal names follow the buffer's point of view (slave modport).
interface bank_xbar_rtn_buf_if #(
  parameter int CH_NUM = bank_pkg::CH_NUM_DEF,
  parameter int ROB_W  = bank_pkg::ROB_W_DEF,
  parameter int DATA_W = bank_pkg::DATA_W_DEF
);
  localparam int CH_W = bank_pkg::ch_w_f(CH_NUM);

  logic                     sc_xbar_valid_i;
  logic                     sc_xbar_ready_o;
  logic [CH_W-1:0]          sc_xbar_channel_id_i;
  logic [ROB_W-1:0]         sc_xbar_rob_num_i;
  logic [DATA_W-1:0]        sc_xbar_data_i;
  logic [CH_NUM-1:0]        xbar_rtn_valid_o;
  logic [CH_NUM-1:0]        xbar_rtn_ready_i;
  logic [CH_NUM*ROB_W-1:0]  xbar_rtn_rob_num_o;
  logic [CH_NUM*DATA_W-1:0] xbar_rtn_data_o;
  logic [CH_NUM-1:0]        xbar_isu_credit_o;
  logic                     rtn_err_o;

  modport master (
    output sc_xbar_valid_i, sc_xbar_channel_id_i, sc_xbar_rob_num_i, sc_xbar_data_i,
    output xbar_rtn_ready_i,
    input  sc_xbar_ready_o, xbar_rtn_valid_o, xbar_rtn_rob_num_o, xbar_rtn_data_o,
    input  xbar_isu_credit_o, rtn_err_o
  );

  modport slave (
    input  sc_xbar_valid_i, sc_xbar_channel_id_i, sc_xbar_rob_num_i, sc_xbar_data_i,
    input  xbar_rtn_ready_i,
    output sc_xbar_ready_o, xbar_rtn_valid_o, xbar_rtn_rob_num_o, xbar_rtn_data_o,
    output xbar_isu_credit_o, rtn_err_o
  );

endinterface

// File: rtl/bank_rtn_fifo.sv
// Single-channel synchronous FIFO with occupancy count and async active-high reset.
module bank_rtn_fifo
  import bank_pkg::*;
#(
  parameter int  DEPTH  = DEPTH_DEF,
  parameter type beat_t = rtn_beat_t
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  push_i,
  input  beat_t wdata_i,
  input  logic  pop_i,
  output beat_t rdata_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  beat_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_s, pop_s;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == {CNT_W{1'b0}});
  assign rdata_o = mem_q[rd_ptr_q];

  // Next-state pointers and count; overflow/underflow requests are ignored.
  always_comb begin
    push_s = push_i & ~full_o;
    pop_s  = pop_i & ~empty_o;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/bank_xbar_rtn_buf.sv
// Per-channel return buffer between bank SRAM controller and crossbar.
// Optional same-cycle bypass into an empty channel: BANK_XBAR_RTN_BYPASS_EN.
module bank_xbar_rtn_buf
  import bank_pkg::*;
#(
  parameter int CH_NUM = CH_NUM_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ROB_W  = ROB_W_DEF
) (
  input logic               clk_i,
  input logic               rst_i,
  bank_xbar_rtn_buf_if.slave bus
);

  localparam int CH_W = ch_w_f(CH_NUM);

  typedef struct packed {
    logic [ROB_W-1:0]  rob_num;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t                    in_beat_s;
  beat_t                    fifo_head_s [CH_NUM];
  beat_t                    head_s [CH_NUM];
  logic [CH_NUM-1:0]        enq_s, push_s, pop_s, full_s, empty_s, valid_s, deq_s;
  logic                     sel_full_s, illegal_s, ready_s;
  logic [CH_NUM*ROB_W-1:0]  rob_vec_s;
  logic [CH_NUM*DATA_W-1:0] data_vec_s;
  logic [CH_NUM-1:0]        credit_q;
  logic                     err_q;

  // Id decode and input ready; ready never looks at the output side.
  always_comb begin
    in_beat_s  = '{rob_num: bus.sc_xbar_rob_num_i, data: bus.sc_xbar_data_i};
    illegal_s  = (32'(bus.sc_xbar_channel_id_i) >= 32'(CH_NUM));
    sel_full_s = 1'b0;
    for (int c = 0; c < CH_NUM; c++) begin
      sel_full_s = sel_full_s | ((32'(bus.sc_xbar_channel_id_i) == 32'(c)) & full_s[c]);
    end
    ready_s = ~rst_i & ~sel_full_s;
    for (int c = 0; c < CH_NUM; c++) begin
      enq_s[c] = bus.sc_xbar_valid_i & ready_s & (32'(bus.sc_xbar_channel_id_i) == 32'(c));
    end
  end

  // Per-channel head selection, push/pop and output packing.
  always_comb begin
    rob_vec_s  = {(CH_NUM*ROB_W){1'b0}};
    data_vec_s = {(CH_NUM*DATA_W){1'b0}};
    for (int c = 0; c < CH_NUM; c++) begin
`ifdef BANK_XBAR_RTN_BYPASS_EN
      // An empty channel shows the incoming beat now; skip the write if it leaves at once.
      push_s[c]  = enq_s[c] & ~(empty_s[c] & bus.xbar_rtn_ready_i[c]);
      valid_s[c] = ~empty_s[c] | enq_s[c];
      head_s[c]  = empty_s[c] ? in_beat_s : fifo_head_s[c];
`else
      push_s[c]  = enq_s[c];
      valid_s[c] = ~empty_s[c];
      head_s[c]  = fifo_head_s[c];
`endif
      pop_s[c] = ~empty_s[c] & bus.xbar_rtn_ready_i[c];
      deq_s[c] = valid_s[c] & bus.xbar_rtn_ready_i[c];
      rob_vec_s[c*ROB_W +: ROB_W]    = head_s[c].rob_num;
      data_vec_s[c*DATA_W +: DATA_W] = head_s[c].data;
    end
  end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    bank_rtn_fifo #(
      .DEPTH  (DEPTH),
      .beat_t (beat_t)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push_s[c]),
      .wdata_i (in_beat_s),
      .pop_i   (pop_s[c]),
      .rdata_o (fifo_head_s[c]),
      .full_o  (full_s[c]),
      .empty_o (empty_s[c])
    );
  end

  // Credit pulses trail each delivered beat by one cycle; error flag is sticky.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credit_q <= {CH_NUM{1'b0}};
      err_q    <= 1'b0;
    end else begin
      credit_q <= deq_s;
      err_q    <= err_q | (bus.sc_xbar_valid_i & ready_s & illegal_s);
    end
  end

  assign bus.sc_xbar_ready_o    = ready_s;
  assign bus.xbar_rtn_valid_o   = valid_s;
  assign bus.xbar_rtn_rob_num_o = rob_vec_s;
  assign bus.xbar_rtn_data_o    = data_vec_s;
  assign bus.xbar_isu_credit_o  = credit_q;
  assign bus.rtn_err_o          = err_q;

endmodule

// File: tb/tb_bank_xbar_rtn_buf.sv
// Directed bench for bank_xbar_rtn_buf (default build, CH_NUM=3, DEPTH=4).
module tb_bank_xbar_rtn_buf;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk_i = ~clk_i;

  bank_xbar_rtn_buf_if #(.CH_NUM(3), .ROB_W(3), .DATA_W(128)) bus ();

  bank_xbar_rtn_buf #(.CH_NUM(3), .DEPTH(4), .DATA_W(128), .ROB_W(3)) u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    logic       v;
    logic [1:0] id;
    logic [2:0] rob;
    logic [2:0] rdy;
    logic       e_ready;
    logic [2:0] e_valid;
    logic [2:0] e_credit;
    logic       e_err;
    int         chk_ch;
    logic [2:0] e_rob;
  } vec_t;

  vec_t tbl [20];

  logic [1:0] seq_id  [16];
  logic [2:0] seq_rob [16];
  logic [2:0] got0 [$];
  logic [2:0] got1 [$];
  logic [2:0] got2 [$];
  int crd0, crd1, crd2, data_bad;

  function automatic logic [127:0] make_data(input logic [2:0] r);
    logic [127:0] base;
    base = {16{8'hA5}};
    return base ^ {125'd0, r};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] id, input logic [2:0] rob, input logic [2:0] rdy);
    bus.sc_xbar_valid_i      = v;
    bus.sc_xbar_channel_id_i = id;
    bus.sc_xbar_rob_num_i    = rob;
    bus.sc_xbar_data_i       = make_data(rob);
    bus.xbar_rtn_ready_i     = rdy;
  endtask

  // Streams seq_id/seq_rob, records every delivered beat per channel.
  task automatic run_seq(input int n, input logic [2:0] rdy_base, input logic [2:0] tog_mask, input int drain);
    int sent = 0;
    int cyc = 0;
    int idle = 0;
    logic tog = 1'b0;
    logic acc;
    logic [2:0] rdy;
    logic [2:0] r;
    int idx;
    got0.delete(); got1.delete(); got2.delete();
    crd0 = 0; crd1 = 0; crd2 = 0; data_bad = 0;
    while ((sent < n || idle < drain) && cyc < 300) begin
      idx = (sent < n) ? sent : 0;
      rdy = tog ? (rdy_base ^ tog_mask) : rdy_base;
      drive(sent < n, seq_id[idx], seq_rob[idx], rdy);
      #1;
      for (int c = 0; c < 3; c++) begin
        if (bus.xbar_rtn_valid_o[c] && rdy[c]) begin
          r = bus.xbar_rtn_rob_num_o[c*3 +: 3];
          if (bus.xbar_rtn_data_o[c*128 +: 128] !== make_data(r)) data_bad++;
          if (c == 0) got0.push_back(r);
          else if (c == 1) got1.push_back(r);
          else got2.push_back(r);
        end
      end
      crd0 += int'(bus.xbar_isu_credit_o[0]);
      crd1 += int'(bus.xbar_isu_credit_o[1]);
      crd2 += int'(bus.xbar_isu_credit_o[2]);
      acc = bus.sc_xbar_valid_i & bus.sc_xbar_ready_o;
      @(posedge clk_i); #1;
      if (acc) sent++;
      if (sent >= n) idle++;
      tog = ~tog;
      cyc++;
    end
    chk("seq_done_in_budget", 128'(cyc < 300), 128'(1));
    chk("seq_data_intact", 128'(data_bad), 128'(0));
    drive(1'b0, 2'd0, 3'd0, 3'b000);
  endtask

  initial begin
    //          v     id     rob    rdy     rdy_o valid   credit  err   ch rob
    tbl[0]  = '{1'b0, 2'd0, 3'd0, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 3, 3'd0};
    tbl[1]  = '{1'b1, 2'd1, 3'd5, 3'b010, 1'b1, 3'b000, 3'b000, 1'b0, 3, 3'd0};
    tbl[2]  = '{1'b0, 2'd0, 3'd0, 3'b010, 1'b1, 3'b010, 3'b000, 1'b0, 1, 3'd5};
    tbl[3]  = '{1'b0, 2'd0, 3'd0, 3'b000, 1'b1, 3'b000, 3'b010, 1'b0, 3, 3'd0};
    tbl[4]  = '{1'b0, 2'd0, 3'd0, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 3, 3'd0};
    tbl[5]  = '{1'b1, 2'd0, 3'd0, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 3, 3'd0};
    tbl[6]  = '{1'b1, 2'd0, 3'd1, 3'b000, 1'b1, 3'b001, 3'b000, 1'b0, 0, 3'd0};
    tbl[7]  = '{1'b1, 2'd0, 3'd2, 3'b000, 1'b1, 3'b001, 3'b000, 1'b0, 3, 3'd0};
    tbl[8]  = '{1'b1, 2'd0, 3'd3, 3'b000, 1'b1, 3'b001, 3'b000, 1'b0, 3, 3'd0};
    tbl[9]  = '{1'b1, 2'd0, 3'd4, 3'b000, 1'b0, 3'b001, 3'b000, 1'b0, 3, 3'd0};
    tbl[10] = '{1'b1, 2'd2, 3'd6, 3'b000, 1'b1, 3'b001, 3'b000, 1'b0, 3, 3'd0};
    tbl[11] = '{1'b1, 2'd0, 3'd4, 3'b001, 1'b0, 3'b101, 3'b000, 1'b0, 2, 3'd6};
    tbl[12] = '{1'b0, 2'd0, 3'd0, 3'b101, 1'b1, 3'b101, 3'b001, 1'b0, 0, 3'd1};
    tbl[13] = '{1'b0, 2'd0, 3'd0, 3'b001, 1'b1, 3'b001, 3'b101, 1'b0, 0, 3'd2};
    tbl[14] = '{1'b0, 2'd0, 3'd0, 3'b001, 1'b1, 3'b001, 3'b001, 1'b0, 0, 3'd3};
    tbl[15] = '{1'b0, 2'd0, 3'd0, 3'b000, 1'b1, 3'b000, 3'b001, 1'b0, 3, 3'd0};
    tbl[16] = '{1'b0, 2'd0, 3'd0, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 3, 3'd0};
    tbl[17] = '{1'b1, 2'd3, 3'd7, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 3, 3'd0};
    tbl[18] = '{1'b0, 2'd0, 3'd0, 3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 3, 3'd0};
    tbl[19] = '{1'b0, 2'd0, 3'd0, 3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 3, 3'd0};

    drive(1'b0, 2'd0, 3'd0, 3'b000);
    @(posedge clk_i); @(posedge clk_i); #1;
    chk("rst_ready", 128'(bus.sc_xbar_ready_o), 128'(0));
    chk("rst_valid", 128'(bus.xbar_rtn_valid_o), 128'(0));
    chk("rst_credit", 128'(bus.xbar_isu_credit_o), 128'(0));
    chk("rst_err", 128'(bus.rtn_err_o), 128'(0));
    rst_i = 1'b0;

    // Single beat, fill-to-full with a side channel, drain order, illegal id.
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].id, tbl[i].rob, tbl[i].rdy);
      #1;
      chk($sformatf("v%0d_ready", i), 128'(bus.sc_xbar_ready_o), 128'(tbl[i].e_ready));
      chk($sformatf("v%0d_valid", i), 128'(bus.xbar_rtn_valid_o), 128'(tbl[i].e_valid));
      chk($sformatf("v%0d_credit", i), 128'(bus.xbar_isu_credit_o), 128'(tbl[i].e_credit));
      chk($sformatf("v%0d_err", i), 128'(bus.rtn_err_o), 128'(tbl[i].e_err));
      if (tbl[i].chk_ch < 3) begin
        chk($sformatf("v%0d_rob", i), 128'(bus.xbar_rtn_rob_num_o[tbl[i].chk_ch*3 +: 3]), 128'(tbl[i].e_rob));
        chk($sformatf("v%0d_data", i), bus.xbar_rtn_data_o[tbl[i].chk_ch*128 +: 128], make_data(tbl[i].e_rob));
      end
      @(posedge clk_i); #1;
    end

    // Pointer wrap: 10 beats on ch2, ch2 ready toggling every cycle.
    for (int i = 0; i < 10; i++) begin
      seq_id[i]  = 2'd2;
      seq_rob[i] = 3'(i % 8);
    end
    run_seq(10, 3'b000, 3'b100, 12);
    chk("wrap_count", 128'(got2.size()), 128'(10));
    for (int i = 0; i < got2.size(); i++) begin
      chk($sformatf("wrap_rob%0d", i), 128'(got2[i]), 128'(i % 8));
    end
    chk("wrap_credits", 128'(crd2), 128'(10));
    chk("wrap_others_idle", 128'(got0.size() + got1.size()), 128'(0));

    // Head-of-line: ch0 filled and stalled, ch1/ch2 interleaved behind it.
    for (int i = 0; i < 4; i++) begin
      seq_id[i]  = 2'd0;
      seq_rob[i] = 3'(i);
    end
    seq_id[4] = 2'd1; seq_rob[4] = 3'd1;
    seq_id[5] = 2'd2; seq_rob[5] = 3'd4;
    seq_id[6] = 2'd1; seq_rob[6] = 3'd2;
    seq_id[7] = 2'd2; seq_rob[7] = 3'd5;
    seq_id[8] = 2'd1; seq_rob[8] = 3'd3;
    seq_id[9] = 2'd2; seq_rob[9] = 3'd6;
    run_seq(10, 3'b110, 3'b000, 6);
    chk("hol_ch0_stalled", 128'(got0.size()), 128'(0));
    chk("hol_ch1_count", 128'(got1.size()), 128'(3));
    chk("hol_ch2_count", 128'(got2.size()), 128'(3));
    for (int i = 0; i < got1.size(); i++) chk($sformatf("hol_ch1_rob%0d", i), 128'(got1[i]), 128'(i + 1));
    for (int i = 0; i < got2.size(); i++) chk($sformatf("hol_ch2_rob%0d", i), 128'(got2[i]), 128'(i + 4));
    chk("hol_credits", 128'({crd0[3:0], crd1[3:0], crd2[3:0]}), 128'(12'h033));
    #1;
    chk("hol_ch0_full_ready", 128'(bus.sc_xbar_ready_o), 128'(0));
    chk("hol_ch0_valid", 128'(bus.xbar_rtn_valid_o), 128'(3'b001));

    // Reset mid-stream with ch0 loaded and a credit pending.
    drive(1'b0, 2'd0, 3'd0, 3'b001);
    @(posedge clk_i); #1;
    drive(1'b0, 2'd0, 3'd0, 3'b000);
    #1;
    chk("pre_rst_credit", 128'(bus.xbar_isu_credit_o), 128'(3'b001));
    chk("pre_rst_valid", 128'(bus.xbar_rtn_valid_o), 128'(3'b001));
    chk("pre_rst_err_sticky", 128'(bus.rtn_err_o), 128'(1));
    #2;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_valid", 128'(bus.xbar_rtn_valid_o), 128'(0));
    chk("mid_rst_credit", 128'(bus.xbar_isu_credit_o), 128'(0));
    chk("mid_rst_ready", 128'(bus.sc_xbar_ready_o), 128'(0));
    chk("mid_rst_err", 128'(bus.rtn_err_o), 128'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    drive(1'b1, 2'd0, 3'd0, 3'b000);
    #1;
    chk("post_rst_ready", 128'(bus.sc_xbar_ready_o), 128'(1));
    chk("post_rst_valid", 128'(bus.xbar_rtn_valid_o), 128'(0));
    drive(1'b0, 2'd0, 3'd0, 3'b000);
    @(posedge clk_i); #1;
    chk("post_rst_flushed", 128'(bus.xbar_rtn_valid_o), 128'(0));
    chk("post_rst_no_credit", 128'(bus.xbar_isu_credit_o), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
